// File: rtl/clk_div_gen.sv
// Programmable clock divider: glitch-free registered divided clock, tick strobe,
// divisor changes deferred to period boundaries, completed-period counter.
module clk_div_gen #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] div_active,
  output logic             div_pending,
  output logic             div_err,
  output logic [CNT_W-1:0] period_count,
  output logic             running
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [DIV_W-1:0]   r_cnt;
  logic               r_clk_out;
  logic               r_tick;
  logic [DIV_W-1:0]   r_div_active;
  logic [DIV_W-1:0]   r_pend_val;
  logic               r_div_pending;
  logic               r_div_err;
  logic [CNT_W-1:0]   r_period_count;

  logic [DIV_W:0]     w_half;
  logic [DIV_W:0]     w_cnt_inc;
  logic               w_boundary;
  logic               w_load_ok;
  logic               w_load_bad;

  assign w_half     = ({1'b0, r_div_active} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
  assign w_cnt_inc  = {1'b0, r_cnt} + {{DIV_W{1'b0}}, 1'b1};
  assign w_boundary = (r_state != S_IDLE) &&
                      (r_cnt == r_div_active - {{(DIV_W-1){1'b0}}, 1'b1});
  assign w_load_ok  = div_load && (div_value > DIV_W'(1));
  assign w_load_bad = div_load && (div_value <= DIV_W'(1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (en) w_state_next = S_RUN;
      S_RUN:   if (!en) w_state_next = S_DRAIN;
      S_DRAIN: begin
        // Re-enable while draining resumes seamlessly, even on the boundary edge.
        if (en)              w_state_next = S_RUN;
        else if (w_boundary) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_clk_out      <= 1'b0;
      r_tick         <= 1'b0;
      r_div_active   <= DIV_W'(DEFAULT_DIV);
      r_pend_val     <= '0;
      r_div_pending  <= 1'b0;
      r_div_err      <= 1'b0;
      r_period_count <= '0;
    end else begin
      r_div_err <= w_load_bad;
      if (r_state == S_IDLE) begin
        r_cnt     <= '0;
        r_clk_out <= en;
        r_tick    <= en;
        if (w_load_ok) r_div_active <= div_value;
      end else begin
        if (w_boundary) begin
          r_cnt          <= '0;
          r_period_count <= r_period_count + CNT_W'(1);
          r_clk_out      <= (w_state_next != S_IDLE);
          r_tick         <= (w_state_next != S_IDLE);
          if (r_div_pending) begin
            r_div_active  <= r_pend_val;
            r_div_pending <= 1'b0;
          end
        end else begin
          r_cnt     <= w_cnt_inc[DIV_W-1:0];
          r_clk_out <= (w_cnt_inc < w_half);
          r_tick    <= 1'b0;
        end
        // A load on a boundary edge queues behind the value applied there.
        if (w_load_ok) begin
          r_pend_val    <= div_value;
          r_div_pending <= 1'b1;
        end
      end
    end
  end

  assign clk_out      = r_clk_out;
  assign tick         = r_tick;
  assign div_active   = r_div_active;
  assign div_pending  = r_div_pending;
  assign div_err      = r_div_err;
  assign period_count = r_period_count;
  assign running      = (r_state != S_IDLE);

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: period-position model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_clk_div_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       div_load;
  logic [7:0] div_value;
  logic       clk_out, tick, div_pending, div_err, running;
  logic [7:0] div_active;
  logic [15:0] period_count;
  logic       clk_out4, tick4, div_pending4, div_err4, running4;
  logic [7:0] div_active4;
  logic [3:0] period_count4;

  int n_total = 0;
  int n_bad   = 0;

  clk_div_gen u_dut (
    .clk(clk), .rst(rst), .en(en), .div_load(div_load), .div_value(div_value),
    .clk_out(clk_out), .tick(tick), .div_active(div_active),
    .div_pending(div_pending), .div_err(div_err),
    .period_count(period_count), .running(running)
  );

  clk_div_gen #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .div_load(div_load), .div_value(div_value),
    .clk_out(clk_out4), .tick(tick4), .div_active(div_active4),
    .div_pending(div_pending4), .div_err(div_err4),
    .period_count(period_count4), .running(running4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_total++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Model: position within the current period, divisor in force, pending slot.
  bit m_valid = 1'b0;
  bit m_on, m_drain, m_pend, m_err, m_tick, m_legal;
  int m_pos, m_n, m_pendv, m_periods;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1; m_on = 1'b0; m_drain = 1'b0; m_pos = 0; m_n = 4;
      m_pend = 1'b0; m_pendv = 0; m_periods = 0; m_err = 1'b0; m_tick = 1'b0;
    end else begin
      m_err   = div_load && (int'(div_value) < 2);
      m_legal = div_load && (int'(div_value) >= 2);
      m_tick  = 1'b0;
      if (!m_on) begin
        if (m_legal) m_n = int'(div_value);
        if (en) begin
          m_on = 1'b1; m_drain = 1'b0; m_pos = 0; m_tick = 1'b1;
        end
      end else begin
        if (m_pos == m_n - 1) begin
          m_periods++;
          if (m_pend) begin m_n = m_pendv; m_pend = 1'b0; end
          m_pos = 0;
          if (m_drain && !en) m_on = 1'b0;
          else                m_tick = 1'b1;
        end else begin
          m_pos++;
        end
        m_drain = !en;
        if (m_legal) begin m_pendv = int'(div_value); m_pend = 1'b1; end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_clk_out", int'(clk_out), int'(m_on && (m_pos < (m_n + 1) / 2)));
      chk("m_tick", int'(tick), int'(m_tick));
      chk("m_div_active", int'(div_active), m_n);
      chk("m_div_pending", int'(div_pending), int'(m_pend));
      chk("m_div_err", int'(div_err), int'(m_err));
      chk("m_period_count", int'(period_count), m_periods % 65536);
      chk("m_running", int'(running), int'(m_on));
      chk("m_period_count4", int'(period_count4), m_periods % 16);
      chk("m_clk_out4", int'(clk_out4), int'(m_on && (m_pos < (m_n + 1) / 2)));
    end
  end

  task automatic pulse_load(input int v);
    div_load = 1'b1;
    div_value = 8'(v);
    @(negedge clk);
    div_load = 1'b0;
  endtask

  task automatic wait_active(input int v, input string nm);
    int k = 0;
    while (int'(div_active) != v && k < 40) begin @(negedge clk); k++; end
    chk(nm, int'(div_active), v);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (running && k < 60) begin @(negedge clk); k++; end
    chk(nm, int'(running), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_value = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_div_active", int'(div_active), 4);
    chk("rst_period", int'(period_count), 0);
    chk("rst_running", int'(running), 0);
    rst = 1'b0;
    @(negedge clk);

    // N=4 free run: 1,1,0,0 starting one cycle after en
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t1_clk", int'(clk_out), int'((i % 4) < 2));
      chk("t1_tick", int'(tick), int'((i % 4) == 0));
    end
    @(negedge clk);
    chk("t1_period3", int'(period_count), 3);

    // load 5 at cnt=1
    @(negedge clk);
    pulse_load(5);
    chk("t2_pending", int'(div_pending), 1);
    chk("t2_active_old", int'(div_active), 4);
    @(negedge clk);
    chk("t2_low_cnt3", int'(clk_out), 0);
    @(negedge clk);
    chk("t2_active_new", int'(div_active), 5);
    chk("t2_pending_clr", int'(div_pending), 0);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk("t2_n5_clk", int'(clk_out), int'(k < 3));
    end
    @(negedge clk);
    chk("t2_n5_tick", int'(tick), 1);

    // illegal loads while running N=4
    pulse_load(4);
    wait_active(4, "t3_back_to_4");
    pulse_load(0);
    chk("t3_err0", int'(div_err), 1);
    pulse_load(1);
    chk("t3_err1", int'(div_err), 1);
    @(negedge clk);
    chk("t3_err_clr", int'(div_err), 0);
    chk("t3_active", int'(div_active), 4);
    chk("t3_pending", int'(div_pending), 0);

    // N=6, drop en at cnt=1
    en = 1'b0;
    wait_idle("t4_idle0");
    pulse_load(6);
    chk("t4_idle_load", int'(div_active), 6);
    en = 1'b1;
    @(negedge clk);
    chk("t4_first_high", int'(clk_out), 1);
    @(negedge clk);
    en = 1'b0;
    for (int k = 2; k < 6; k++) begin
      @(negedge clk);
      chk("t4_drain_clk", int'(clk_out), int'(k < 3));
      chk("t4_drain_run", int'(running), 1);
    end
    @(negedge clk);
    chk("t4_idle_run", int'(running), 0);
    chk("t4_idle_clk", int'(clk_out), 0);
    repeat (2) @(negedge clk);
    chk("t4_stay_low", int'(clk_out), 0);

    // re-raise en at cnt=3
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("t4b_run", int'(running), 1);
    @(negedge clk);
    @(negedge clk);
    chk("t4b_clk", int'(clk_out), 1);
    chk("t4b_tick", int'(tick), 1);

    // reset mid-high with N=7
    pulse_load(7);
    wait_active(7, "t5_active7");
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    chk("t5_clk", int'(clk_out), 0);
    chk("t5_tick", int'(tick), 0);
    chk("t5_period", int'(period_count), 0);
    chk("t5_active", int'(div_active), 4);
    chk("t5_running", int'(running), 0);
    rst = 1'b0;
    @(negedge clk);

    // N=2 loaded with en, 17 periods, CNT_W=4 wrap
    div_load = 1'b1; div_value = 8'd2; en = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    chk("t6_active", int'(div_active), 2);
    chk("t6_first", int'(clk_out), 1);
    for (int j = 1; j <= 34; j++) begin
      @(negedge clk);
      chk("t6_clk", int'(clk_out), int'((j % 2) == 0));
      if (j == 30) chk("t6_cnt4_15", int'(period_count4), 15);
      if (j == 32) chk("t6_cnt4_0", int'(period_count4), 0);
      if (j == 34) chk("t6_cnt4_1", int'(period_count4), 1);
    end
    chk("t6_cnt16", int'(period_count), 17);
    en = 1'b0;
    wait_idle("t6_idle");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Programmable clock divider sitting directly downstream of the free-running clock source (`clk`, 10 ns period in simulation).
- Produces a registered, glitch-free divided clock `clk_out`, a one-cycle `tick` enable aligned to each `clk_out` rising edge, and a completed-period counter.
- Divisor changes are accepted at any time and take effect only at a period boundary, so downstream logic never sees a runt pulse.

Parameters:
- DIV_W, 8, width of the divisor.
- DEFAULT_DIV, 4, divisor loaded at reset. Legal range 2..2^DIV_W-1.
- CNT_W, 16, width of `period_count`.

Ports:
- clk  input  1  system clock from the clock source.
- rst  input  1  synchronous reset, active-high.
- en  input  1  run request; level-sensitive.
- div_load  input  1  one-cycle strobe; samples `div_value`.
- div_value  input  DIV_W  requested divisor N.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse coincident with each rising edge of `clk_out`.
- div_active  output  DIV_W  divisor currently in use.
- div_pending  output  1  a loaded divisor is waiting for a period boundary.
- div_err  output  1  one-cycle pulse when `div_load` carries an illegal value.
- period_count  output  CNT_W  number of completed periods; wraps.
- running  output  1  high when the FSM is in RUN or DRAIN.

Behaviour:
- All state is updated on the rising edge of `clk`. All outputs are registered.
- Reset (synchronous, active-high, overrides everything, including mid-period):
  - `state`=IDLE, `cnt`=0, `clk_out`=0, `tick`=0.
  - `div_active`=DEFAULT_DIV, `pend_val`=0, `div_pending`=0, `div_err`=0, `period_count`=0.
- Phase split for divisor N: H = ceil(N/2) cycles high, then N-H cycles low. `cnt` runs 0..N-1, and `clk_out` is high while `cnt` < H.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - `cnt`=0 and `clk_out`=0.
  - When `en`=1 is sampled: go to RUN, with `cnt`=0, `clk_out`=1, `tick`=1 at that same edge. Latency from `en` to the first rising edge of `clk_out` is 1 cycle.
- RUN:
  - If `cnt`==N-1 (boundary):
    - `cnt`<=0, `clk_out`<=1, `tick`<=1, `period_count`<=`period_count`+1.
    - If `div_pending`=1, then `div_active`<=`pend_val` and `div_pending`<=0. The new N governs the period that starts at this edge.
  - Otherwise: `cnt`<=`cnt`+1, `clk_out`<=(`cnt`+1 < H), `tick`<=0.
  - If `en`=0 is sampled, go to DRAIN. Counting continues unchanged.
- DRAIN:
  - Counts exactly as in RUN.
  - At the boundary: go to IDLE, `clk_out`<=0, `tick`=0, `period_count`+1. Any pending divisor is applied.
  - If `en`=1 is sampled before the boundary, return to RUN with no discontinuity in `cnt` or `clk_out`.
- Divisor load:
  - Legal `div_value` (2..2^DIV_W-1):
    - In IDLE: `div_active`<=`div_value` immediately.
    - In RUN/DRAIN: `pend_val`<=`div_value`, `div_pending`<=1.
    - A second load while pending overwrites `pend_val`.
  - Illegal `div_value` (0 or 1): `div_err`=1 for one cycle. `div_active`, `pend_val` and `div_pending` are unchanged.
  - Load on the same edge as a boundary: the already-pending value, if any, is applied at this boundary. The new value becomes pending for the next boundary.
  - When `en` rises and a legal `div_load` arrive in the same IDLE cycle, the loaded value governs the first period.
- `period_count` wraps from 2^CNT_W-1 to 0 with no flag.
- `running` = (`state` != IDLE).

Test Plan:
- Reset, then `en`=1 held, N=4 → `clk_out` pattern 1,1,0,0 repeating starting 1 cycle after `en`; `tick` every 4th cycle; `period_count`=3 after 12 cycles of running.
- `div_load` with 5 at `cnt`=1 of an N=4 period → that period still lasts 4 cycles; next period is 3 high, 2 low; `div_pending` high until the boundary; `div_active` changes 4→5 at the boundary.
- `div_load` with 0, then `div_load` with 1, while running N=4 → two `div_err` pulses; `div_active` stays 4; waveform undisturbed.
- `en` dropped at `cnt`=1 with N=6 → `clk_out` completes 3 high, 3 low, then stays 0; state reaches IDLE; `running`=0. Repeat with `en` re-raised at `cnt`=3 → continuous waveform, no glitch.
- `rst` asserted mid-high-phase with N=7 → next edge `clk_out`=0, `tick`=0, `period_count`=0, `div_active`=4.
- CNT_W=4, N=2, run 17 periods → `period_count` wraps 15→0→1.
